// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the two-port BRAM arbiter.
// Imported by the arbiter top and its picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_e;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way winner select.
// Round-robin or CPU-first with a starvation override for port D.
module arb_pick2
  import mem_arb_pkg::*;
#(
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic c_req,
  input  logic d_req,
  input  logic rr_last,
  input  logic starved,
  output logic winner
);

  logic both;

  assign both = c_req & d_req;

  always_comb begin
    winner = PORT_C;
    unique case (1'b1)
      (d_req && !c_req):
        winner = PORT_D;
      (both && CPU_PRIORITY):
        winner = starved ? PORT_D : PORT_C;
      (both && !CPU_PRIORITY):
        winner = ~rr_last;
      default:
        winner = PORT_C;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port BRAM between the CPU (C) and a DMA master (D).
// One grant per IDLE sample; reads occupy three cycles, writes two.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int CPU_PRIORITY = 0,
  parameter int MAX_STARVE   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_MAX =
    STARVE_W'(MAX_STARVE);

  arb_state_e state, state_nx;

  logic                sel;
  logic                rr_last;
  logic                winner;
  logic                grant;
  logic                starved;
  logic                pick_we;
  logic [STARVE_W-1:0] starve_cnt, starve_nx;

  logic          c_gnt_nx, d_gnt_nx;
  logic          c_rvalid_nx, d_rvalid_nx;
  logic          mem_we_nx;
  logic [DW-1:0] c_rdata_nx, d_rdata_nx;

  assign grant   = (state == IDLE) && (c_req || d_req);
  assign starved = (starve_cnt == STARVE_MAX);
  assign pick_we = (winner == PORT_D) ? d_we : c_we;

  arb_pick2 #(
    .CPU_PRIORITY(CPU_PRIORITY != 0)
  ) u_pick (
    .c_req  (c_req),
    .d_req  (d_req),
    .rr_last(rr_last),
    .starved(starved),
    .winner (winner)
  );

  // D only ages when it asked and lost; any D grant clears it.
  always_comb begin
    starve_nx = starve_cnt;
    if (grant) begin
      if (winner == PORT_D)
        starve_nx = '0;
      else if (d_req && !starved)
        starve_nx = starve_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (c_req || d_req) state_nx = ACCESS;
      ACCESS:  state_nx = mem_we ? IDLE : RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    c_gnt_nx    = 1'b0;
    d_gnt_nx    = 1'b0;
    c_rvalid_nx = 1'b0;
    d_rvalid_nx = 1'b0;
    mem_we_nx   = 1'b0;
    c_rdata_nx  = c_rdata;
    d_rdata_nx  = d_rdata;
    unique case (state)
      IDLE: begin
        if (grant) begin
          c_gnt_nx  = (winner == PORT_C);
          d_gnt_nx  = (winner == PORT_D);
          mem_we_nx = pick_we;
        end
      end
      RESP: begin
        if (sel == PORT_D) begin
          d_rvalid_nx = 1'b1;
          d_rdata_nx  = mem_rdata;
        end else begin
          c_rvalid_nx = 1'b1;
          c_rdata_nx  = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      sel        <= PORT_C;
      rr_last    <= PORT_D;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      c_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      c_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      c_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      mem_we     <= mem_we_nx;
      c_gnt      <= c_gnt_nx;
      d_gnt      <= d_gnt_nx;
      c_rvalid   <= c_rvalid_nx;
      d_rvalid   <= d_rvalid_nx;
      c_rdata    <= c_rdata_nx;
      d_rdata    <= d_rdata_nx;
      if (grant) begin
        sel       <= winner;
        rr_last   <= winner;
        mem_addr  <= (winner == PORT_D) ? d_addr : c_addr;
        mem_wdata <= (winner == PORT_D) ? d_wdata : c_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table, multi-cycle sequences and random traffic on two
// arbiters (round-robin and CPU-priority) against an event-scheduled model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        c_gnt;
    logic        c_rvalid;
    logic [15:0] c_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
  } obs_t;

  typedef struct {
    obs_t        e;
    logic        rr_last;
    int          starve;
    int          free_at;
    int          commit_at;
    int          rd_at;
    logic        rd_port;
    logic [15:0] rd_val;
    logic [15:0] cm_addr;
    logic [15:0] cm_data;
  } mdl_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic c_req = 1'b0, c_we = 1'b0;
  logic d_req = 1'b0, d_we = 1'b0;
  logic [15:0] c_addr = '0, c_wdata = '0;
  logic [15:0] d_addr = '0, d_wdata = '0;

  logic r_c_gnt, r_c_rvalid, r_d_gnt, r_d_rvalid, r_mem_we;
  logic [15:0] r_c_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
  logic [15:0] r_mem_rdata;
  logic p_c_gnt, p_c_rvalid, p_d_gnt, p_d_rvalid, p_mem_we;
  logic [15:0] p_c_rdata, p_d_rdata, p_mem_addr, p_mem_wdata;
  logic [15:0] p_mem_rdata;

  obs_t        obs [2];
  mdl_t        m [2];
  logic [15:0] ram_r [int];
  logic [15:0] ram_p [int];
  logic [15:0] shadow [int];
  int          edge_n   = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          q_r [$];
  int          q_p [$];
  vec_t        tbl [6];

  always #5 clk = ~clk;

  mem_arbiter u_rr (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(r_c_gnt), .c_rvalid(r_c_rvalid), .c_rdata(r_c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(r_d_gnt), .d_rvalid(r_d_rvalid), .d_rdata(r_d_rdata),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_we(r_mem_we),
    .mem_rdata(r_mem_rdata)
  );

  mem_arbiter #(.CPU_PRIORITY(1), .MAX_STARVE(3)) u_pri (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(p_c_gnt), .c_rvalid(p_c_rvalid), .c_rdata(p_c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we),
    .mem_rdata(p_mem_rdata)
  );

  assign obs[0] = {r_c_gnt, r_c_rvalid, r_c_rdata, r_d_gnt, r_d_rvalid,
                   r_d_rdata, r_mem_addr, r_mem_wdata, r_mem_we};
  assign obs[1] = {p_c_gnt, p_c_rvalid, p_c_rdata, p_d_gnt, p_d_rvalid,
                   p_d_rdata, p_mem_addr, p_mem_wdata, p_mem_we};

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h3C3C);
  endfunction

  // Block RAMs: registered read of the old contents, write on mem_we.
  always @(posedge clk) begin
    r_mem_rdata <= ram_r.exists(int'(r_mem_addr)) ?
                   ram_r[int'(r_mem_addr)] : init_val(r_mem_addr);
    if (r_mem_we) ram_r[int'(r_mem_addr)] = r_mem_wdata;
  end

  always @(posedge clk) begin
    p_mem_rdata <= ram_p.exists(int'(p_mem_addr)) ?
                   ram_p[int'(p_mem_addr)] : init_val(p_mem_addr);
    if (p_mem_we) ram_p[int'(p_mem_addr)] = p_mem_wdata;
  end

  function automatic logic [15:0] mdl_mem(input int k, input logic [15:0] a);
    int key;
    key = k * 65536 + int'(a);
    return shadow.exists(key) ? shadow[key] : init_val(a);
  endfunction

  // Reference model: each grant schedules its future events by edge number.
  task automatic model_step(input int k);
    logic        w;
    logic        we;
    logic [15:0] a;
    logic [15:0] wd;
    m[k].e.c_gnt    = 1'b0;
    m[k].e.d_gnt    = 1'b0;
    m[k].e.c_rvalid = 1'b0;
    m[k].e.d_rvalid = 1'b0;
    m[k].e.mem_we   = 1'b0;
    if (m[k].commit_at == edge_n)
      shadow[k * 65536 + int'(m[k].cm_addr)] = m[k].cm_data;
    if (!reset) begin
      m[k].e         = '0;
      m[k].rr_last   = 1'b1;
      m[k].starve    = 0;
      m[k].free_at   = edge_n + 1;
      m[k].commit_at = -1;
      m[k].rd_at     = -1;
      return;
    end
    if (m[k].rd_at == edge_n) begin
      if (m[k].rd_port) begin
        m[k].e.d_rvalid = 1'b1;
        m[k].e.d_rdata  = m[k].rd_val;
      end else begin
        m[k].e.c_rvalid = 1'b1;
        m[k].e.c_rdata  = m[k].rd_val;
      end
    end
    if (edge_n >= m[k].free_at && (c_req || d_req)) begin
      if (c_req && d_req) begin
        if (k == 1) w = (m[k].starve == 3);
        else        w = !m[k].rr_last;
        if (w) m[k].starve = 0;
        else if (m[k].starve < ((k == 1) ? 3 : 4)) m[k].starve++;
      end else begin
        w = d_req;
        if (w) m[k].starve = 0;
      end
      m[k].rr_last     = w;
      we               = w ? d_we : c_we;
      a                = w ? d_addr : c_addr;
      wd               = w ? d_wdata : c_wdata;
      m[k].e.c_gnt     = !w;
      m[k].e.d_gnt     = w;
      m[k].e.mem_we    = we;
      m[k].e.mem_addr  = a;
      m[k].e.mem_wdata = wd;
      if (we) begin
        m[k].commit_at = edge_n + 1;
        m[k].cm_addr   = a;
        m[k].cm_data   = wd;
        m[k].free_at   = edge_n + 2;
      end else begin
        m[k].rd_at   = edge_n + 2;
        m[k].rd_port = w;
        m[k].rd_val  = mdl_mem(k, a);
        m[k].free_at = edge_n + 3;
      end
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (edge_n > 0) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== m[k].e) begin
          n_fail++;
          $display("FAIL scoreboard dut%0d edge %0d: got %h expected %h",
                   k, edge_n, obs[k], m[k].e);
        end
      end
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    c_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic do_xact(input vec_t v);
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
    end
    tick();
    check("gnt_n1", v.port ? obs[0].d_gnt : obs[0].c_gnt, 1);
    check("other_gnt", v.port ? obs[0].c_gnt : obs[0].d_gnt, 0);
    c_req = 1'b0;
    d_req = 1'b0;
    if (v.we) begin
      check("mem_we_n1", obs[0].mem_we, 1);
      check("mem_addr", obs[0].mem_addr, v.addr);
      check("mem_wdata", obs[0].mem_wdata, v.wdata);
      tick();
      check("mem_we_n2", obs[0].mem_we, 0);
    end else begin
      check("mem_we_rd", obs[0].mem_we, 0);
      tick();
      check("rvalid_n2", obs[0].c_rvalid | obs[0].d_rvalid, 0);
      tick();
      check("rvalid_n3", v.port ? obs[0].d_rvalid : obs[0].c_rvalid, 1);
      check("other_rvalid", v.port ? obs[0].c_rvalid : obs[0].d_rvalid, 0);
      check("rdata", v.port ? obs[0].d_rdata : obs[0].c_rdata, v.exp_rdata);
    end
    tick();
  endtask

  initial begin
    int both;
    int dg;
    tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    tbl[3] = '{1'b0, 1'b1, 16'h0030, 16'h5A5A, 16'h0000};
    tbl[4] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5A5A};
    tbl[5] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};

    reset_dut();
    check("rst_outs", 32'(obs[0] != '0), 0);
    check("rst_state", 32'(u_rr.state), 32'(IDLE));
    for (int i = 0; i < 6; i++) do_xact(tbl[i]);

    // Both ports hold reads continuously.
    reset_dut();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    both = 0;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (obs[0].c_gnt) q_r.push_back(0);
      if (obs[0].d_gnt) q_r.push_back(1);
      if (obs[1].c_gnt) q_p.push_back(0);
      if (obs[1].d_gnt) q_p.push_back(1);
      if (obs[0].c_gnt && obs[0].d_gnt) both++;
      if (obs[1].c_gnt && obs[1].d_gnt) both++;
      if (obs[1].d_gnt) check("starve_clr", 32'(u_pri.starve_cnt), 0);
    end
    c_req = 1'b0;
    d_req = 1'b0;
    check("rr_grants", 32'(q_r.size() >= 8), 1);
    check("pri_grants", 32'(q_p.size() >= 8), 1);
    for (int i = 0; i < 8; i++) begin
      check("rr_order", (i < q_r.size()) ? q_r[i] : 2, i % 2);
      check("pri_order", (i < q_p.size()) ? q_p[i] : 2, 32'((i % 4) == 3));
    end
    check("both_gnt", both, 0);
    tick();
    tick();
    tick();

    // Reset lands while a CPU write is in ACCESS.
    reset_dut();
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0040; c_wdata = 16'h7777;
    tick();
    check("wr_gnt", obs[0].c_gnt, 1);
    check("wr_we", obs[0].mem_we, 1);
    reset = 1'b0;
    c_req = 1'b0;
    tick();
    check("abort_outs", 32'(obs[0] != '0), 0);
    check("abort_state", 32'(u_rr.state), 32'(IDLE));
    reset = 1'b1;
    tick();
    check("abort_rvalid", obs[0].c_rvalid | obs[0].d_rvalid, 0);
    do_xact(tbl[0]);

    // D raises then withdraws its request while C is mid-read.
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    tick();
    check("drop_cgnt", obs[0].c_gnt, 1);
    c_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    dg = 0;
    tick();
    if (obs[0].d_gnt) dg++;
    d_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs[0].d_gnt) dg++;
    end
    check("drop_dgnt", dg, 0);
    check("drop_idle", 32'(u_rr.state), 32'(IDLE));

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 49) != 0);
      c_req   = ($urandom_range(0, 9) < 6);
      d_req   = ($urandom_range(0, 9) < 6);
      c_we    = $urandom_range(0, 1) != 0;
      d_we    = $urandom_range(0, 1) != 0;
      c_addr  = 16'($urandom_range(0, 31));
      d_addr  = 16'($urandom_range(0, 31));
      c_wdata = 16'($urandom);
      d_wdata = 16'($urandom);
      tick();
    end
    reset = 1'b1;
    c_req = 1'b0;
    d_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
